axis_demux_1to2: RTL and testbench
==================================

AXIS_DEMUX_1TO2 -- requirements
Module: axis_demux_1to2

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the tdata width of all streams.
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of each packet counter.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have ports s_axis_data / s_axis_valid / s_axis_ready / s_axis_last: input / input / output / input, DATA_W/1/1/1 bits; the single upstream stream.
REQ-006 SHALL have ports m_axis_data_1 / m_axis_valid_1 / m_axis_ready_1 / m_axis_last_1: output / output / input / output, DATA_W/1/1/1 bits; downstream port 1.
REQ-007 SHALL have ports m_axis_data_2 / m_axis_valid_2 / m_axis_ready_2 / m_axis_last_2, with the same directions and widths; downstream port 2.
REQ-008 SHALL have port sel, input, 1 bit, route select: 0 routes to port 1, 1 routes to port 2.
REQ-009 SHALL have ports pkt_cnt_1 and pkt_cnt_2, output, CNT_W bits each; completed-packet counts.
REQ-010 SHALL have port busy, output, 1 bit, high while a packet is open (state not IDLE).

Function
REQ-011 SHALL use an FSM with states IDLE, PKT_1 and PKT_2.
- Route target is sel in IDLE, port 1 in PKT_1, and port 2 in PKT_2.
REQ-012 SHALL treat an input beat as accepted when s_axis_valid and s_axis_ready are both high on a clock edge.
REQ-013 SHALL leave IDLE on an accepted beat with last=0, going to PKT_1 if sel=0 or PKT_2 if sel=1.
- On an accepted beat with last=1 it SHALL remain in IDLE (single-beat packet).
REQ-014 SHALL return from PKT_x to IDLE on an accepted beat with last=1; sel SHALL be ignored while in PKT_x.
REQ-015 SHALL register each output port's data, valid and last, with a latency of exactly 1 cycle from input acceptance to m_axis_valid_x high.
REQ-016 SHALL never route a beat to the non-target port, and SHALL never lose, duplicate or reorder beats.
REQ-017 SHALL hold an output beat stable (data, last, valid) until m_axis_ready_x is high; valid SHALL NOT drop without a handshake.
- When no beat is held, m_axis_valid_x=0 and data/last keep their last values.
REQ-018 SHALL let a busy non-target port drain independently while the target port accepts.
- Example: a sel change in IDLE while the last beat of the previous packet is still held on the other port SHALL NOT stall the input.
REQ-019 SHALL increment pkt_cnt_x by 1 on each output handshake of port x with m_axis_last_x=1; the counter SHALL wrap from all-ones to 0.
REQ-020 SHALL drive s_axis_ready=0 whenever the target output stage cannot accept (see REQ-025/026).

Reset
REQ-021 SHALL, while reset_n=0, asynchronously force: state IDLE; s_axis_ready=0; m_axis_valid_x=0; m_axis_last_x=0; m_axis_data_x=0; pkt_cnt_x=0; busy=0.
REQ-022 SHALL discard all buffered beats on reset asserted mid-packet; after release the next accepted beat is treated as a packet start.
REQ-023 SHALL drive s_axis_ready high no earlier than the first clock edge after reset_n deasserts.

Configuration
REQ-024 SHALL use the macro AXIS_DEMUX_SKID_EN.
REQ-025 With AXIS_DEMUX_SKID_EN defined:
- each output SHALL have a 2-entry (main + skid) buffer;
- s_axis_ready SHALL be a pure register output, low only when the target's skid entry is occupied;
- full throughput SHALL be sustained with no combinational ready path.
REQ-026 With AXIS_DEMUX_SKID_EN undefined:
- each output SHALL have a single register stage;
- s_axis_ready = !m_axis_valid_x || m_axis_ready_x for target x (combinational);
- full throughput SHALL be sustained.

Verification
REQ-027 SHALL cover: sel=0, 4-beat packet A0..A3 (last on A3), both readies=1 -> A0..A3 on port 1 one cycle after each input, port 2 valid stays 0, pkt_cnt_1=1.
REQ-028 SHALL cover: sel toggles 0->1 after beat 2 of a 5-beat packet -> all 5 beats on port 1; the next packet goes to port 2.
REQ-029 SHALL cover: single-beat packets 0x11 (sel=0), 0x22 (sel=1), 0x33 (sel=0) back-to-back -> port 1 gets 0x11,0x33; port 2 gets 0x22; busy stays 0.
REQ-030 SHALL cover: m_axis_ready_1=0 for 3 cycles mid-packet -> s_axis_ready drops (skid: after 2 beats buffered), no beat lost, data held stable, order preserved.
REQ-031 SHALL cover: pkt_cnt_2 preloaded by sending 65535 packets (CNT_W=16), then one more -> pkt_cnt_2=0.
REQ-032 SHALL cover: reset_n pulsed low mid-packet with beats buffered -> outputs cleared immediately, then a new packet with sel=1 routes fully to port 2.

Source files
------------

// File: rtl/axis_demux_1to2.sv
// axis_demux_1to2 - routes one AXI-Stream-style input to one of two outputs,
// switching only on packet boundaries.
//
// Build option: define AXIS_DEMUX_SKID_EN to give each output a main+skid
// pair and a registered s_axis_ready. Without it, each output has a single
// register stage and s_axis_ready is combinational from the target port.
//
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   s_axis_data/valid/ready/last    upstream stream
//   m_axis_data/valid/ready/last_1  downstream port 1 (sel=0)
//   m_axis_data/valid/ready/last_2  downstream port 2 (sel=1)
//   sel                             route select, sampled only in IDLE
//   pkt_cnt_1, pkt_cnt_2            completed-packet counters (wrap)
//   busy                            a packet is open (state not IDLE)
//
// state | meaning
// IDLE  | between packets; the next beat goes to the port chosen by sel
// PKT_1 | packet open on port 1; sel ignored until the last beat
// PKT_2 | packet open on port 2; sel ignored until the last beat
module axis_demux_1to2 #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] s_axis_data,
  input  logic              s_axis_valid,
  output logic              s_axis_ready,
  input  logic              s_axis_last,
  output logic [DATA_W-1:0] m_axis_data_1,
  output logic              m_axis_valid_1,
  input  logic              m_axis_ready_1,
  output logic              m_axis_last_1,
  output logic [DATA_W-1:0] m_axis_data_2,
  output logic              m_axis_valid_2,
  input  logic              m_axis_ready_2,
  output logic              m_axis_last_2,
  input  logic              sel,
  output logic [CNT_W-1:0]  pkt_cnt_1,
  output logic [CNT_W-1:0]  pkt_cnt_2,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, PKT_1, PKT_2} state_e;

  state_e state_q, state_d;
  logic   tgt2;
  logic   accept;
  logic [1:0] acc, pop, m_ready;

  // Output stage: index 0 is port 1, index 1 is port 2.
  logic [1:0]             main_v_q, main_v_d;
  logic [1:0]             main_l_q, main_l_d;
  logic [1:0][DATA_W-1:0] main_d_q, main_d_d;
  logic [1:0][CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    tgt2 = sel;
    case (state_q)
      PKT_1:   tgt2 = 1'b0;
      PKT_2:   tgt2 = 1'b1;
      default: tgt2 = sel;
    endcase
  end

  assign accept  = s_axis_valid && s_axis_ready;
  assign acc     = {accept && tgt2, accept && !tgt2};
  assign m_ready = {m_axis_ready_2, m_axis_ready_1};
  assign pop     = main_v_q & m_ready;

  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        IDLE:         if (!s_axis_last) state_d = sel ? PKT_2 : PKT_1;
        PKT_1, PKT_2: if (s_axis_last) state_d = IDLE;
        default:      state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (pop[i] && main_l_q[i]) cnt_d[i] = cnt_q[i] + CNT_W'(1);
    end
  end

`ifdef AXIS_DEMUX_SKID_EN
  logic [1:0]             sk_v_q, sk_v_d;
  logic [1:0]             sk_l_q, sk_l_d;
  logic [1:0][DATA_W-1:0] sk_d_q, sk_d_d;
  logic                   ready_q, ready_d;

  always_comb begin
    main_v_d = main_v_q;
    main_l_d = main_l_q;
    main_d_d = main_d_q;
    sk_v_d   = sk_v_q;
    sk_l_d   = sk_l_q;
    sk_d_d   = sk_d_q;
    for (int i = 0; i < 2; i++) begin
      if (pop[i] || !main_v_q[i]) begin
        // Main is free this cycle: skid (older) moves up first.
        if (sk_v_q[i]) begin
          main_v_d[i] = 1'b1;
          main_l_d[i] = sk_l_q[i];
          main_d_d[i] = sk_d_q[i];
          sk_v_d[i]   = acc[i];
          if (acc[i]) begin
            sk_l_d[i] = s_axis_last;
            sk_d_d[i] = s_axis_data;
          end
        end else if (acc[i]) begin
          main_v_d[i] = 1'b1;
          main_l_d[i] = s_axis_last;
          main_d_d[i] = s_axis_data;
        end else begin
          main_v_d[i] = 1'b0;
        end
      end else if (acc[i]) begin
        sk_v_d[i] = 1'b1;
        sk_l_d[i] = s_axis_last;
        sk_d_d[i] = s_axis_data;
      end
    end
    // Registered ready: in IDLE the next target depends on a sel value we
    // cannot see yet, so both skids must be free.
    case (state_d)
      PKT_1:   ready_d = !sk_v_d[0];
      PKT_2:   ready_d = !sk_v_d[1];
      default: ready_d = !(|sk_v_d);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sk_v_q  <= '0;
      sk_l_q  <= '0;
      sk_d_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      sk_v_q  <= sk_v_d;
      sk_l_q  <= sk_l_d;
      sk_d_q  <= sk_d_d;
      ready_q <= ready_d;
    end
  end

  assign s_axis_ready = ready_q;
`else
  logic ready_en_q, ready_en_d;

  always_comb begin
    main_v_d   = main_v_q;
    main_l_d   = main_l_q;
    main_d_d   = main_d_q;
    ready_en_d = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        main_v_d[i] = 1'b1;
        main_l_d[i] = s_axis_last;
        main_d_d[i] = s_axis_data;
      end else if (pop[i]) begin
        main_v_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ready_en_q <= 1'b0;
    else          ready_en_q <= ready_en_d;
  end

  // ready_en_q keeps ready low until the first edge after reset release.
  assign s_axis_ready = ready_en_q &&
                        (tgt2 ? (!main_v_q[1] || m_axis_ready_2)
                              : (!main_v_q[0] || m_axis_ready_1));
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      main_v_q <= '0;
      main_l_q <= '0;
      main_d_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      main_v_q <= main_v_d;
      main_l_q <= main_l_d;
      main_d_q <= main_d_d;
      cnt_q    <= cnt_d;
    end
  end

  assign m_axis_data_1  = main_d_q[0];
  assign m_axis_valid_1 = main_v_q[0];
  assign m_axis_last_1  = main_l_q[0];
  assign m_axis_data_2  = main_d_q[1];
  assign m_axis_valid_2 = main_v_q[1];
  assign m_axis_last_2  = main_l_q[1];
  assign pkt_cnt_1      = cnt_q[0];
  assign pkt_cnt_2      = cnt_q[1];
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_axis_demux_1to2.sv
module tb_axis_demux_1to2;
  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] s_axis_data;
  logic          s_axis_valid, s_axis_ready, s_axis_last;
  logic [DW-1:0] m_axis_data_1, m_axis_data_2;
  logic          m_axis_valid_1, m_axis_ready_1, m_axis_last_1;
  logic          m_axis_valid_2, m_axis_ready_2, m_axis_last_2;
  logic          sel, busy;
  logic [CW-1:0] pkt_cnt_1, pkt_cnt_2;

  always #5 clk = ~clk;

  axis_demux_1to2 #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid),
    .s_axis_ready(s_axis_ready), .s_axis_last(s_axis_last),
    .m_axis_data_1(m_axis_data_1), .m_axis_valid_1(m_axis_valid_1),
    .m_axis_ready_1(m_axis_ready_1), .m_axis_last_1(m_axis_last_1),
    .m_axis_data_2(m_axis_data_2), .m_axis_valid_2(m_axis_valid_2),
    .m_axis_ready_2(m_axis_ready_2), .m_axis_last_2(m_axis_last_2),
    .sel(sel), .pkt_cnt_1(pkt_cnt_1), .pkt_cnt_2(pkt_cnt_2), .busy(busy)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    longint        acc_cyc;
  } beat_t;

  typedef struct {
    logic          sel;
    logic [DW-1:0] data;
    logic          last;
    int            port;   // expected output: 0 = port 1, 1 = port 2
  } vec_t;

  beat_t sbq0[$];
  beat_t sbq1[$];
  vec_t  tbl[14];

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  int     acc_cnt;
  bit     mon_en, lat_chk, busy_chk, p2_quiet, stall_watch, saw_drop;
  logic [CW-1:0] exp_cnt1, exp_cnt2;
  bit            hold_prev[2];
  logic [DW-1:0] prev_d[2];
  logic          prev_l[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"}, s_axis_ready, 0);
    chk({tag, "_valid_1"}, m_axis_valid_1, 0);
    chk({tag, "_valid_2"}, m_axis_valid_2, 0);
    chk({tag, "_last_1"}, m_axis_last_1, 0);
    chk({tag, "_last_2"}, m_axis_last_2, 0);
    chk({tag, "_data_1"}, m_axis_data_1, 0);
    chk({tag, "_data_2"}, m_axis_data_2, 0);
    chk({tag, "_cnt_1"}, pkt_cnt_1, 0);
    chk({tag, "_cnt_2"}, pkt_cnt_2, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic mon_port(input int p);
    logic v, r, l;
    logic [DW-1:0] d;
    beat_t e;
    bit have;
    if (p == 0) begin v = m_axis_valid_1; r = m_axis_ready_1; d = m_axis_data_1; l = m_axis_last_1; end
    else        begin v = m_axis_valid_2; r = m_axis_ready_2; d = m_axis_data_2; l = m_axis_last_2; end
    if (hold_prev[p]) begin
      chk($sformatf("p%0d_hold_valid", p + 1), v, 1);
      chk($sformatf("p%0d_hold_data", p + 1), d, prev_d[p]);
      chk($sformatf("p%0d_hold_last", p + 1), l, prev_l[p]);
    end
    if (v && r) begin
      have = (p == 0) ? (sbq0.size() > 0) : (sbq1.size() > 0);
      if (!have) begin
        chk($sformatf("p%0d_unexpected_beat_%0h", p + 1, d), have, 1);
      end else begin
        if (p == 0) e = sbq0.pop_front();
        else        e = sbq1.pop_front();
        chk($sformatf("p%0d_data", p + 1), d, e.data);
        chk($sformatf("p%0d_last", p + 1), l, e.last);
        if (lat_chk) chk($sformatf("p%0d_latency", p + 1), cyc - e.acc_cyc, 1);
        if (e.last) begin
          if (p == 0) exp_cnt1 = exp_cnt1 + 1'b1;
          else        exp_cnt2 = exp_cnt2 + 1'b1;
        end
      end
    end
    hold_prev[p] = v && !r;
    prev_d[p]    = d;
    prev_l[p]    = l;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (mon_en && reset_n) begin
        mon_port(0);
        mon_port(1);
        if (busy_chk) chk("busy_single_beat", busy, 0);
        if (p2_quiet) chk("p2_quiet", m_axis_valid_2, 0);
        if (stall_watch && s_axis_valid && !s_axis_ready) saw_drop = 1;
      end else begin
        hold_prev[0] = 0;
        hold_prev[1] = 0;
      end
    end
  endtask

  // Drive one beat starting just after a rising edge; returns after acceptance.
  task automatic send(input logic sl, input logic [DW-1:0] d, input logic l,
                      input int port, output int waits);
    beat_t e;
    sel = sl; s_axis_data = d; s_axis_last = l; s_axis_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!s_axis_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!s_axis_ready) begin
      chk("accept_timeout", waits, 0);
      s_axis_valid = 1'b0;
      return;
    end
    e.data = d; e.last = l; e.acc_cyc = cyc;
    if (port == 0) sbq0.push_back(e);
    else           sbq1.push_back(e);
    acc_cnt++;
    @(posedge clk); #1;
    s_axis_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq0.size() != 0 || sbq1.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_q1_left", sbq0.size(), 0);
    chk("drain_q2_left", sbq1.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    mon_en = 0;
    reset_n = 1'b0;
    s_axis_valid = 1'b0;
    #1;
    chk_reset_vals("rst");
    sbq0.delete();
    sbq1.delete();
    exp_cnt1 = '0;
    exp_cnt2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("ready_before_first_edge", s_axis_ready, 0);
    @(posedge clk); #1;
    chk("ready_after_first_edge", s_axis_ready, 1);
    mon_en = 1;
  endtask

  task automatic apply(input int lo, input int hi);
    int w;
    for (int i = lo; i <= hi; i++) begin
      send(tbl[i].sel, tbl[i].data, tbl[i].last, tbl[i].port, w);
      chk($sformatf("vec%0d_ready_wait", i), w, 0);
    end
  endtask

  initial begin
    int w;
    // sel, data, last, expected port
    tbl[0]  = '{1'b0, 8'hA0, 1'b0, 0};
    tbl[1]  = '{1'b0, 8'hA1, 1'b0, 0};
    tbl[2]  = '{1'b0, 8'hA2, 1'b0, 0};
    tbl[3]  = '{1'b0, 8'hA3, 1'b1, 0};
    tbl[4]  = '{1'b0, 8'hB0, 1'b0, 0};
    tbl[5]  = '{1'b0, 8'hB1, 1'b0, 0};
    tbl[6]  = '{1'b1, 8'hB2, 1'b0, 0};
    tbl[7]  = '{1'b1, 8'hB3, 1'b0, 0};
    tbl[8]  = '{1'b1, 8'hB4, 1'b1, 0};
    tbl[9]  = '{1'b1, 8'hC0, 1'b0, 1};
    tbl[10] = '{1'b1, 8'hC1, 1'b1, 1};
    tbl[11] = '{1'b0, 8'h11, 1'b1, 0};
    tbl[12] = '{1'b1, 8'h22, 1'b1, 1};
    tbl[13] = '{1'b0, 8'h33, 1'b1, 0};

    reset_n = 1'b0; s_axis_valid = 1'b0; s_axis_data = '0; s_axis_last = 1'b0;
    sel = 1'b0; m_axis_ready_1 = 1'b1; m_axis_ready_2 = 1'b1;
    mon_en = 0; lat_chk = 0; busy_chk = 0; p2_quiet = 0; stall_watch = 0; saw_drop = 0;
    hold_prev[0] = 0; hold_prev[1] = 0; acc_cnt = 0;
    fork monitor(); join_none
    #2;
    do_reset();

    // 4-beat packet to port 1, port 2 silent
    lat_chk = 1; p2_quiet = 1;
    apply(0, 3);
    drain();
    p2_quiet = 0;
    chk("cnt1_after_pkt_a", pkt_cnt_1, 1);
    chk("cnt2_after_pkt_a", pkt_cnt_2, 0);

    // sel flips mid-packet, then next packet goes to port 2
    apply(4, 10);
    drain();
    chk("cnt1_after_sel_flip", pkt_cnt_1, exp_cnt1);
    chk("cnt2_after_sel_flip", pkt_cnt_2, exp_cnt2);

    // back-to-back single-beat packets, busy never rises
    busy_chk = 1;
    apply(11, 13);
    busy_chk = 0;
    drain();
    chk("cnt1_after_singles", pkt_cnt_1, exp_cnt1);
    chk("cnt2_after_singles", pkt_cnt_2, exp_cnt2);

    // port 1 holds its last beat; switching to port 2 in IDLE must not stall
    lat_chk = 0;
    m_axis_ready_1 = 1'b0;
    send(1'b0, 8'h61, 1'b1, 0, w);
    send(1'b1, 8'h62, 1'b1, 1, w);
    chk("idle_switch_wait", w, 0);
    repeat (2) @(posedge clk); #1;
    m_axis_ready_1 = 1'b1;
    drain();

    // port 1 stalls for 3 cycles mid-packet
    acc_cnt = 0; saw_drop = 0; stall_watch = 1;
    fork
      begin
        int w2;
        for (int i = 0; i < 8; i++) send(1'b0, 8'(8'h70 + i), (i == 7), 0, w2);
      end
      begin
        int n = 0;
        while (acc_cnt < 2 && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        m_axis_ready_1 = 1'b0;
        repeat (3) @(posedge clk); #1;
        m_axis_ready_1 = 1'b1;
      end
    join
    stall_watch = 0;
    chk("stall_ready_dropped", saw_drop, 1);
    drain();
    chk("cnt1_after_stall", pkt_cnt_1, exp_cnt1);

    // counter wrap on port 2
    do_reset();
    lat_chk = 1;
    for (int i = 0; i < 65535; i++) send(1'b1, 8'(i), 1'b1, 1, w);
    drain();
    chk("cnt2_preload", pkt_cnt_2, 16'hFFFF);
    chk("cnt2_preload_model", pkt_cnt_2, exp_cnt2);
    send(1'b1, 8'hEE, 1'b1, 1, w);
    drain();
    chk("cnt2_wrap", pkt_cnt_2, 0);
    chk("cnt1_during_wrap", pkt_cnt_1, 0);

    // reset mid-packet with beats buffered
    lat_chk = 0;
    m_axis_ready_1 = 1'b0;
    send(1'b0, 8'h51, 1'b0, 0, w);
    sel = 1'b0; s_axis_data = 8'h52; s_axis_last = 1'b0; s_axis_valid = 1'b1;
    @(posedge clk); #2;
    chk("busy_mid_packet", busy, 1);
    chk("held_valid_before_reset", m_axis_valid_1, 1);
    mon_en = 0;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    s_axis_valid = 1'b0;
    sbq0.delete();
    sbq1.delete();
    exp_cnt1 = '0;
    exp_cnt2 = '0;
    m_axis_ready_1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("midrst_ready_before_edge", s_axis_ready, 0);
    @(posedge clk); #1;
    mon_en = 1; lat_chk = 1;
    send(1'b1, 8'h81, 1'b0, 1, w);
    send(1'b1, 8'h82, 1'b0, 1, w);
    send(1'b1, 8'h83, 1'b1, 1, w);
    drain();
    chk("post_reset_cnt2", pkt_cnt_2, 1);
    chk("post_reset_cnt1", pkt_cnt_1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
